// File: rtl/add_result_checker.sv
// add_result_checker: self-checking sink that compares adder outputs against {1'b0,A}+{1'b0,B}.
// Latency: expected value delayed LATENCY cycles to line up with O/C; err_pulse one cycle after the compare.
// Backpressure: none; every aligned in_valid during RUN is compared, and there is no stall path.
// Ports: clk, reset (sync, active-low), start, in_valid, A, B, O, C -> busy, done, pass, err_pulse,
//        err_cnt (saturating), sample_cnt.
// Build option: define ADD_CHECK_CAPTURE_EN to add cap_A/cap_B/cap_O/cap_C/cap_vld, which hold the
//        first mismatching sample of a run.
module add_result_checker #(
    parameter int WIDTH        = 1,
    parameter int LATENCY      = 0,
    parameter int SAMPLE_NUM   = 4,
    parameter int ERR_CNT_BITS = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic                             in_valid,
    input  logic [WIDTH-1:0]                 A,
    input  logic [WIDTH-1:0]                 B,
    input  logic [WIDTH-1:0]                 O,
    input  logic                             C,
    output logic                             busy,
    output logic                             done,
    output logic                             pass,
    output logic                             err_pulse,
    output logic [ERR_CNT_BITS-1:0]          err_cnt,
    output logic [$clog2(SAMPLE_NUM+1)-1:0]  sample_cnt
`ifdef ADD_CHECK_CAPTURE_EN
    ,
    output logic [WIDTH-1:0]                 cap_A,
    output logic [WIDTH-1:0]                 cap_B,
    output logic [WIDTH-1:0]                 cap_O,
    output logic                             cap_C,
    output logic                             cap_vld
`endif
);

    localparam int SCW = $clog2(SAMPLE_NUM + 1);
`ifdef ADD_CHECK_CAPTURE_EN
    // Operands travel with the expected sum so a mismatch can be captured in full.
    localparam int DW = 3 * WIDTH + 1;
`else
    localparam int DW = WIDTH + 1;
`endif

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [WIDTH:0]  exp_sum;
    logic [DW-1:0]   cur_dat;
    logic [DW-1:0]   dly_dat;
    logic            cur_vld;
    logic            dly_vld;
    logic            start_run;
    logic            cmp;
    logic            mism;
    logic            last;

    assign exp_sum   = {1'b0, A} + {1'b0, B};
`ifdef ADD_CHECK_CAPTURE_EN
    assign cur_dat   = {A, B, exp_sum};
`else
    assign cur_dat   = exp_sum;
`endif
    // Only operands presented while running enter the alignment pipe.
    assign cur_vld   = in_valid && (state == S_RUN);
    assign start_run = start && (state != S_RUN);

    generate
        if (LATENCY == 0) begin : g_comb
            assign dly_vld = cur_vld;
            assign dly_dat = cur_dat;
        end else begin : g_pipe
            logic            vld_q [LATENCY];
            logic [DW-1:0]   dat_q [LATENCY];

            always_ff @(posedge clk) begin
                // Valid bits are flushed on reset and on every run start so stale
                // entries from an aborted or finished run never get compared.
                if (!reset || start_run) begin
                    for (int i = 0; i < LATENCY; i++) vld_q[i] <= 1'b0;
                end else begin
                    vld_q[0] <= cur_vld;
                    for (int i = 1; i < LATENCY; i++) vld_q[i] <= vld_q[i-1];
                end
                dat_q[0] <= cur_dat;
                for (int i = 1; i < LATENCY; i++) dat_q[i] <= dat_q[i-1];
            end

            assign dly_vld = vld_q[LATENCY-1];
            assign dly_dat = dat_q[LATENCY-1];
        end
    endgenerate

    // Case inequality: X/Z on the adder outputs is reported as a mismatch in simulation.
    assign mism = ({C, O} !== dly_dat[WIDTH:0]);
    assign cmp  = dly_vld && (state == S_RUN);
    assign last = cmp && (sample_cnt == SCW'(SAMPLE_NUM - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (last)  state_nxt = S_DONE;
            S_DONE:  if (start) state_nxt = S_RUN;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            err_cnt    <= '0;
            sample_cnt <= '0;
            pass       <= 1'b0;
            err_pulse  <= 1'b0;
        end else begin
            err_pulse <= cmp && mism;
            if (start_run) begin
                err_cnt    <= '0;
                sample_cnt <= '0;
                pass       <= 1'b0;
            end else if (cmp) begin
                sample_cnt <= sample_cnt + SCW'(1);
                if (mism && (err_cnt != '1)) err_cnt <= err_cnt + ERR_CNT_BITS'(1);
                // The final compare's own result is folded in here, since err_cnt lags by a cycle.
                if (last) pass <= (err_cnt == '0) && !mism;
            end
        end
    end

`ifdef ADD_CHECK_CAPTURE_EN
    always_ff @(posedge clk) begin
        if (!reset || start_run) begin
            cap_A   <= '0;
            cap_B   <= '0;
            cap_O   <= '0;
            cap_C   <= 1'b0;
            cap_vld <= 1'b0;
        end else if (cmp && mism && !cap_vld) begin
            cap_A   <= dly_dat[3*WIDTH:2*WIDTH+1];
            cap_B   <= dly_dat[2*WIDTH:WIDTH+1];
            cap_O   <= O;
            cap_C   <= C;
            cap_vld <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_add_result_checker.sv
// Testbench for add_result_checker: four checker instances with different parameters beside
// small behavioural adders (correct, faulty, always-wrong, two-stage pipelined).
// Directed vectors with hand-computed expectations; prints a single summary line.
module tb_add_result_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    // u0: WIDTH=1, LATENCY=0, SAMPLE_NUM=4
    logic s0, v0, a0, b0, fault0, o0, c0;
    logic [1:0] sum0;
    logic busy0, done0, pass0, ep0;
    logic [7:0] ec0;
    logic [2:0] sc0;
    assign sum0 = {1'b0, a0} + {1'b0, b0};
    assign o0   = (fault0 && a0 && b0) ? 1'b1 : sum0[0];
    assign c0   = sum0[1];

    // u1 (LATENCY=1, deliberately wrong) and u2 (LATENCY=2) watch the same 2-stage 4-bit adder
    logic s4, v4;
    logic [3:0] a4, b4, o4;
    logic c4;
    logic [4:0] st1, st2;
    always_ff @(posedge clk) begin
        st1 <= {1'b0, a4} + {1'b0, b4};
        st2 <= st1;
    end
    assign o4 = st2[3:0];
    assign c4 = st2[4];
    logic busy1, done1, pass1, ep1, busy2, done2, pass2, ep2;
    logic [7:0] ec1, ec2;
    logic [3:0] sc1, sc2;

    // u3: WIDTH=1, LATENCY=0, SAMPLE_NUM=6, ERR_CNT_BITS=2
    logic s3, v3, a3, b3, wrong3, o3, c3;
    logic [1:0] sum3;
    logic busy3, done3, pass3, ep3;
    logic [1:0] ec3;
    logic [2:0] sc3;
    assign sum3 = {1'b0, a3} + {1'b0, b3};
    assign {c3, o3} = wrong3 ? ~sum3 : sum3;

`ifdef ADD_CHECK_CAPTURE_EN
    logic cA0, cB0, cO0, cC0, cV0, cA3, cB3, cO3, cC3, cV3, cC1, cV1, cC2, cV2;
    logic [3:0] cA1, cB1, cO1, cA2, cB2, cO2;
`endif

    add_result_checker #(.WIDTH(1), .LATENCY(0), .SAMPLE_NUM(4), .ERR_CNT_BITS(8)) u0 (
        .clk(clk), .reset(reset), .start(s0), .in_valid(v0), .A(a0), .B(b0), .O(o0), .C(c0),
        .busy(busy0), .done(done0), .pass(pass0), .err_pulse(ep0), .err_cnt(ec0), .sample_cnt(sc0)
`ifdef ADD_CHECK_CAPTURE_EN
        , .cap_A(cA0), .cap_B(cB0), .cap_O(cO0), .cap_C(cC0), .cap_vld(cV0)
`endif
    );

    add_result_checker #(.WIDTH(4), .LATENCY(1), .SAMPLE_NUM(8), .ERR_CNT_BITS(8)) u1 (
        .clk(clk), .reset(reset), .start(s4), .in_valid(v4), .A(a4), .B(b4), .O(o4), .C(c4),
        .busy(busy1), .done(done1), .pass(pass1), .err_pulse(ep1), .err_cnt(ec1), .sample_cnt(sc1)
`ifdef ADD_CHECK_CAPTURE_EN
        , .cap_A(cA1), .cap_B(cB1), .cap_O(cO1), .cap_C(cC1), .cap_vld(cV1)
`endif
    );

    add_result_checker #(.WIDTH(4), .LATENCY(2), .SAMPLE_NUM(8), .ERR_CNT_BITS(8)) u2 (
        .clk(clk), .reset(reset), .start(s4), .in_valid(v4), .A(a4), .B(b4), .O(o4), .C(c4),
        .busy(busy2), .done(done2), .pass(pass2), .err_pulse(ep2), .err_cnt(ec2), .sample_cnt(sc2)
`ifdef ADD_CHECK_CAPTURE_EN
        , .cap_A(cA2), .cap_B(cB2), .cap_O(cO2), .cap_C(cC2), .cap_vld(cV2)
`endif
    );

    add_result_checker #(.WIDTH(1), .LATENCY(0), .SAMPLE_NUM(6), .ERR_CNT_BITS(2)) u3 (
        .clk(clk), .reset(reset), .start(s3), .in_valid(v3), .A(a3), .B(b3), .O(o3), .C(c3),
        .busy(busy3), .done(done3), .pass(pass3), .err_pulse(ep3), .err_cnt(ec3), .sample_cnt(sc3)
`ifdef ADD_CHECK_CAPTURE_EN
        , .cap_A(cA3), .cap_B(cB3), .cap_O(cO3), .cap_C(cC3), .cap_vld(cV3)
`endif
    );

    // {valid, A, B}; eight valid entries with gaps, all sums distinct from their neighbours
    localparam logic [8:0] LAT_VEC [10] = '{
        {1'b1, 4'd3,  4'd4},  {1'b1, 4'd9,  4'd9},  {1'b0, 4'd0,  4'd0},
        {1'b1, 4'd15, 4'd1},  {1'b1, 4'd5,  4'd6},  {1'b1, 4'd12, 4'd13},
        {1'b0, 4'd0,  4'd0},  {1'b1, 4'd1,  4'd2},  {1'b1, 4'd8,  4'd7},
        {1'b1, 4'd14, 4'd15}
    };

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; s0 = 1'b1; v0 = 1'b1; a0 = 1'b1; b0 = 1'b1; fault0 = 1'b0;
        s4 = 1'b1; v4 = 1'b1; a4 = 4'd1; b4 = 4'd2;
        s3 = 1'b1; v3 = 1'b1; a3 = 1'b0; b3 = 1'b0; wrong3 = 1'b0;
        repeat (3) tick();
        n_tests++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %0b want 0", busy0); end
        n_tests++; if (done0 !== 1'b0) begin n_fail++; $display("FAIL rst_done got %0b want 0", done0); end
        n_tests++; if (pass0 !== 1'b0) begin n_fail++; $display("FAIL rst_pass got %0b want 0", pass0); end
        n_tests++; if (ep0 !== 1'b0) begin n_fail++; $display("FAIL rst_err_pulse got %0b want 0", ep0); end
        n_tests++; if (ec0 !== 8'd0) begin n_fail++; $display("FAIL rst_err_cnt got %0d want 0", ec0); end
        n_tests++; if (sc0 !== 3'd0) begin n_fail++; $display("FAIL rst_sample_cnt got %0d want 0", sc0); end
        n_tests++; if (busy2 !== 1'b0) begin n_fail++; $display("FAIL rst_busy_u2 got %0b want 0", busy2); end
        reset = 1'b1; s0 = 1'b0; v0 = 1'b0; s4 = 1'b0; v4 = 1'b0; s3 = 1'b0; v3 = 1'b0;
        tick();
    endtask

    task automatic test_exhaustive();
        int pulses = 0;
        s0 = 1'b1; tick(); s0 = 1'b0;
        n_tests++; if (busy0 !== 1'b1) begin n_fail++; $display("FAIL exh_busy got %0b want 1", busy0); end
        for (int i = 0; i < 4; i++) begin
            a0 = i[1]; b0 = i[0]; v0 = 1'b1;
            tick();
            if (ep0 === 1'b1) pulses++;
        end
        v0 = 1'b0;
        n_tests++; if (done0 !== 1'b1) begin n_fail++; $display("FAIL exh_done got %0b want 1", done0); end
        n_tests++; if (pass0 !== 1'b1) begin n_fail++; $display("FAIL exh_pass got %0b want 1", pass0); end
        n_tests++; if (ec0 !== 8'd0) begin n_fail++; $display("FAIL exh_err_cnt got %0d want 0", ec0); end
        n_tests++; if (sc0 !== 3'd4) begin n_fail++; $display("FAIL exh_sample_cnt got %0d want 4", sc0); end
        n_tests++; if (pulses != 0) begin n_fail++; $display("FAIL exh_pulses got %0d want 0", pulses); end
        // extra valid samples in DONE must not be counted
        v0 = 1'b1; a0 = 1'b1; b0 = 1'b1; fault0 = 1'b1;
        repeat (2) tick();
        v0 = 1'b0; fault0 = 1'b0;
        n_tests++; if (sc0 !== 3'd4) begin n_fail++; $display("FAIL done_ignore_cnt got %0d want 4", sc0); end
        n_tests++; if (ec0 !== 8'd0) begin n_fail++; $display("FAIL done_ignore_err got %0d want 0", ec0); end
    endtask

    task automatic test_fault();
        int pulses = 0;
        fault0 = 1'b1;
        s0 = 1'b1; tick(); s0 = 1'b0;
        n_tests++; if (done0 !== 1'b0) begin n_fail++; $display("FAIL flt_restart_done got %0b want 0", done0); end
        for (int i = 0; i < 5; i++) begin
            a0 = i[1]; b0 = i[0]; v0 = (i < 4);
            tick();
            if (ep0 === 1'b1) pulses++;
        end
        v0 = 1'b0;
        n_tests++; if (ec0 !== 8'd1) begin n_fail++; $display("FAIL flt_err_cnt got %0d want 1", ec0); end
        n_tests++; if (pulses != 1) begin n_fail++; $display("FAIL flt_pulses got %0d want 1", pulses); end
        n_tests++; if (pass0 !== 1'b0) begin n_fail++; $display("FAIL flt_pass got %0b want 0", pass0); end
        n_tests++; if (done0 !== 1'b1) begin n_fail++; $display("FAIL flt_done got %0b want 1", done0); end
`ifdef ADD_CHECK_CAPTURE_EN
        n_tests++; if ({cV0, cA0, cB0, cO0, cC0} !== 5'b11111) begin
            n_fail++; $display("FAIL flt_capture got %b want 11111", {cV0, cA0, cB0, cO0, cC0});
        end
`endif
        fault0 = 1'b0;
    endtask

    task automatic test_latency();
        s4 = 1'b1; tick(); s4 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            {v4, a4, b4} = LAT_VEC[i];
            tick();
        end
        v4 = 1'b0;
        repeat (3) tick();
        n_tests++; if (done2 !== 1'b1) begin n_fail++; $display("FAIL lat2_done got %0b want 1", done2); end
        n_tests++; if (pass2 !== 1'b1) begin n_fail++; $display("FAIL lat2_pass got %0b want 1", pass2); end
        n_tests++; if (ec2 !== 8'd0) begin n_fail++; $display("FAIL lat2_err_cnt got %0d want 0", ec2); end
        n_tests++; if (sc2 !== 4'd8) begin n_fail++; $display("FAIL lat2_sample_cnt got %0d want 8", sc2); end
        n_tests++; if (ec1 == 8'd0) begin n_fail++; $display("FAIL lat1_err_cnt got %0d want >0", ec1); end
        n_tests++; if (pass1 !== 1'b0) begin n_fail++; $display("FAIL lat1_pass got %0b want 0", pass1); end
    endtask

    task automatic test_saturation();
        wrong3 = 1'b1;
        s3 = 1'b1; tick(); s3 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            a3 = i[0]; b3 = i[1]; v3 = 1'b1;
            tick();
        end
        v3 = 1'b0;
        n_tests++; if (ec3 !== 2'd3) begin n_fail++; $display("FAIL sat_err_cnt got %0d want 3", ec3); end
        n_tests++; if (sc3 !== 3'd6) begin n_fail++; $display("FAIL sat_sample_cnt got %0d want 6", sc3); end
        n_tests++; if ({done3, pass3} !== 2'b10) begin n_fail++; $display("FAIL sat_done_pass got %b want 10", {done3, pass3}); end
        wrong3 = 1'b0;
        s3 = 1'b1; tick(); s3 = 1'b0;
        n_tests++; if (ec3 !== 2'd0) begin n_fail++; $display("FAIL restart_err_clear got %0d want 0", ec3); end
        n_tests++; if (sc3 !== 3'd0) begin n_fail++; $display("FAIL restart_cnt_clear got %0d want 0", sc3); end
        n_tests++; if ({busy3, done3} !== 2'b10) begin n_fail++; $display("FAIL restart_state got %b want 10", {busy3, done3}); end
        for (int i = 0; i < 6; i++) begin
            a3 = i[1]; b3 = i[0]; v3 = 1'b1;
            tick();
        end
        v3 = 1'b0;
        n_tests++; if (ec3 !== 2'd0) begin n_fail++; $display("FAIL restart_err_cnt got %0d want 0", ec3); end
        n_tests++; if ({done3, pass3} !== 2'b11) begin n_fail++; $display("FAIL restart_done_pass got %b want 11", {done3, pass3}); end
    endtask

    task automatic test_midrun_reset();
        s0 = 1'b1; s4 = 1'b1; tick(); s0 = 1'b0; s4 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            v0 = (i < 2); a0 = i[0]; b0 = 1'b1;
            v4 = 1'b1; a4 = 4'(i + 2); b4 = 4'(3 * i);
            tick();
        end
        v0 = 1'b0;
        n_tests++; if (sc0 !== 3'd2) begin n_fail++; $display("FAIL mid_pre_cnt0 got %0d want 2", sc0); end
        n_tests++; if (sc2 !== 4'd2) begin n_fail++; $display("FAIL mid_pre_cnt2 got %0d want 2", sc2); end
        reset = 1'b0; tick();
        n_tests++; if ({busy0, done0} !== 2'b00) begin n_fail++; $display("FAIL mid_state got %b want 00", {busy0, done0}); end
        n_tests++; if (sc0 !== 3'd0) begin n_fail++; $display("FAIL mid_cnt0 got %0d want 0", sc0); end
        n_tests++; if (sc2 !== 4'd0) begin n_fail++; $display("FAIL mid_cnt2 got %0d want 0", sc2); end
        reset = 1'b1; v4 = 1'b0;
        s4 = 1'b1; tick(); s4 = 1'b0;
        repeat (4) tick();
        n_tests++; if (sc2 !== 4'd0) begin n_fail++; $display("FAIL stale_cnt got %0d want 0", sc2); end
        n_tests++; if (busy2 !== 1'b1) begin n_fail++; $display("FAIL stale_busy got %0b want 1", busy2); end
    endtask

    initial begin
        test_reset();
        test_exhaustive();
        test_fault();
        test_latency();
        test_saturation();
        test_midrun_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
